// File: rtl/spi_flash_rd_if.sv
// Command/data stream and SPI-peripheral register bus of spi_flash_rd.
// master = reader core, slave = command source, data sink and SPI peripheral.
interface spi_flash_rd_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [23:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        data_valid_o;
  logic [7:0]  data_o;
  logic        data_ready_i;
  logic        done_o;
  logic        m_req_valid_o;
  logic [31:0] m_req_addr_o;
  logic [31:0] m_req_value_o;
  logic [3:0]  m_req_wstrb_o;
  logic        m_req_ready_i;
  logic        m_resp_valid_i;
  logic [31:0] m_resp_value_i;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, data_ready_i,
           m_req_ready_i, m_resp_valid_i, m_resp_value_i,
    output cmd_ready_o, data_valid_o, data_o, done_o,
           m_req_valid_o, m_req_addr_o, m_req_value_o, m_req_wstrb_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, data_ready_i,
           m_req_ready_i, m_resp_valid_i, m_resp_value_i,
    input  cmd_ready_o, data_valid_o, data_o, done_o,
           m_req_valid_o, m_req_addr_o, m_req_value_o, m_req_wstrb_o
  );
endinterface

// File: rtl/spi_flash_rd.sv
// SPI flash read sequencer driving a register-mapped SPI peripheral.
// Define SPI_FLASH_FAST_READ_EN for opcode 0x0B plus one dummy byte.
module spi_flash_rd #(
  parameter logic [31:0] SPI_BASE = 32'h0000_0000,
  parameter logic [15:0] CLK_DIV  = 16'd4
) (
  input  logic clk_i,
  input  logic rst_i,
  spi_flash_rd_if.master bus
);
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE    = 8'h0B;
  localparam logic [9:0] HDR_BYTES = 10'd5;
`else
  localparam logic [7:0] OPCODE    = 8'h03;
  localparam logic [9:0] HDR_BYTES = 10'd4;
`endif
  localparam logic [7:0] OFF_TX   = 8'h00;
  localparam logic [7:0] OFF_RX   = 8'h04;
  localparam logic [7:0] OFF_CS   = 8'h08;
  localparam logic [7:0] OFF_DIV  = 8'h0C;
  localparam logic [7:0] OFF_STAT = 8'h10;

  typedef enum logic [2:0] {INIT_DIV, IDLE, CS_LOW, TX_WR, POLL, RX_RD, OUT, CS_HIGH} state_t;

  state_t      state_reg;
  logic [23:0] addr_reg;
  logic [9:0]  tx_idx_reg;     // index of the byte currently on the wire
  logic [9:0]  tx_end_reg;     // header bytes + data bytes
  logic        wait_resp_reg;

  logic        req_write;
  logic [7:0]  req_off;
  logic [31:0] req_value;
  logic [7:0]  tx_byte;
  logic        bus_state;
  logic        resp_done;
  logic [8:0]  len_bytes;

  always_comb begin
    tx_byte = 8'hFF;
    case (tx_idx_reg)
      10'd0:   tx_byte = OPCODE;
      10'd1:   tx_byte = addr_reg[23:16];
      10'd2:   tx_byte = addr_reg[15:8];
      10'd3:   tx_byte = addr_reg[7:0];
      default: tx_byte = 8'hFF;
    endcase
    req_write = 1'b1;
    req_off   = OFF_TX;
    req_value = {24'd0, tx_byte};
    bus_state = 1'b1;
    case (state_reg)
      INIT_DIV: begin req_off = OFF_DIV; req_value = {16'd0, CLK_DIV}; end
      CS_LOW:   begin req_off = OFF_CS;  req_value = 32'd0; end
      TX_WR:    ;
      POLL:     begin req_write = 1'b0; req_off = OFF_STAT; req_value = 32'd0; end
      RX_RD:    begin req_write = 1'b0; req_off = OFF_RX;   req_value = 32'd0; end
      CS_HIGH:  begin req_off = OFF_CS;  req_value = 32'd1; end
      default:  bus_state = 1'b0;
    endcase
  end

  assign resp_done = wait_resp_reg && bus.m_resp_valid_i;
  assign len_bytes = (bus.cmd_len_i == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg         <= INIT_DIV;
      addr_reg          <= 24'd0;
      tx_idx_reg        <= 10'd0;
      tx_end_reg        <= 10'd0;
      wait_resp_reg     <= 1'b0;
      bus.cmd_ready_o   <= 1'b0;
      bus.data_valid_o  <= 1'b0;
      bus.data_o        <= 8'd0;
      bus.done_o        <= 1'b0;
      bus.m_req_valid_o <= 1'b0;
      bus.m_req_addr_o  <= 32'd0;
      bus.m_req_value_o <= 32'd0;
      bus.m_req_wstrb_o <= 4'd0;
    end else begin
      bus.done_o <= 1'b0;
      // One request in flight: issue, wait for accept, then wait for response.
      if (bus.m_req_valid_o && bus.m_req_ready_i) begin
        bus.m_req_valid_o <= 1'b0;
        wait_resp_reg     <= 1'b1;
      end else if (bus_state && !bus.m_req_valid_o && !wait_resp_reg) begin
        bus.m_req_valid_o <= 1'b1;
        bus.m_req_addr_o  <= SPI_BASE + {24'd0, req_off};
        bus.m_req_value_o <= req_value;
        bus.m_req_wstrb_o <= req_write ? 4'hF : 4'h0;
      end
      if (resp_done) wait_resp_reg <= 1'b0;

      case (state_reg)
        INIT_DIV: if (resp_done) begin
          state_reg       <= IDLE;
          bus.cmd_ready_o <= 1'b1;
        end
        IDLE: if (bus.cmd_valid_i && bus.cmd_ready_o) begin
          addr_reg        <= bus.cmd_addr_i;
          tx_idx_reg      <= 10'd0;
          tx_end_reg      <= HDR_BYTES + {1'b0, len_bytes};
          bus.cmd_ready_o <= 1'b0;
          state_reg       <= CS_LOW;
        end
        CS_LOW: if (resp_done) state_reg <= TX_WR;
        TX_WR:  if (resp_done) state_reg <= POLL;
        POLL: if (resp_done && !bus.m_resp_value_i[0]) begin
          if (tx_idx_reg >= HDR_BYTES) begin
            state_reg <= RX_RD;
          end else begin
            tx_idx_reg <= tx_idx_reg + 10'd1;
            state_reg  <= TX_WR;
          end
        end
        RX_RD: if (resp_done) begin
          bus.data_o       <= bus.m_resp_value_i[7:0];
          bus.data_valid_o <= 1'b1;
          state_reg        <= OUT;
        end
        OUT: if (bus.data_ready_i) begin
          bus.data_valid_o <= 1'b0;
          if (tx_idx_reg + 10'd1 < tx_end_reg) begin
            tx_idx_reg <= tx_idx_reg + 10'd1;
            state_reg  <= TX_WR;
          end else begin
            state_reg <= CS_HIGH;
          end
        end
        CS_HIGH: if (resp_done) begin
          bus.done_o      <= 1'b1;
          bus.cmd_ready_o <= 1'b1;
          state_reg       <= IDLE;
        end
        default: state_reg <= INIT_DIV;
      endcase
    end
  end
endmodule
